// File: rtl/priority_arbiter_pkg.sv
// Shared definitions for the 4-requester arbiter: state encoding, sizes and a
// one-hot helper.
package priority_arbiter_pkg;

  localparam int unsigned NumReq = 4;
  localparam int unsigned IdxW   = 2;
  // Wide enough for the largest legal hold limit (255).
  localparam int unsigned HoldW  = 8;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StBusy = 1'b1
  } state_e;

  // Binary requester index to one-hot grant vector.
  function automatic logic [NumReq-1:0] idx_to_onehot(logic [IdxW-1:0] idx);
    logic [NumReq-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/priority_arbiter_prio_enc.sv
// 4-to-2 priority encoder: bit 3 has the highest priority. valid is low when
// no input bit is set, in which case idx is 0.
module prio_enc4 (
  input  logic [3:0] req,
  output logic [1:0] idx,
  output logic       valid
);

  // Highest set bit wins.
  always_comb begin
    idx   = 2'd0;
    valid = 1'b1;
    if (req[3]) begin
      idx = 2'd3;
    end else if (req[2]) begin
      idx = 2'd2;
    end else if (req[1]) begin
      idx = 2'd1;
    end else if (req[0]) begin
      idx = 2'd0;
    end else begin
      valid = 1'b0;
    end
  end

endmodule

// File: rtl/priority_arbiter.sv
// Four-requester arbiter with bounded hold time and registered grant.
// A holder keeps the grant while its request stays high, up to MAX_HOLD
// cycles; it is then revoked, excluded from one arbitration, and timeout
// pulses for one cycle. Arbitration is fixed priority (req[3] highest) by
// default; defining PRIORITY_ARBITER_RR_EN switches to round-robin starting
// one past the last granted index.
module priority_arbiter
  import priority_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       val,
  output logic       timeout
);

  state_e            state_q, state_d;
  logic [NumReq-1:0] gnt_q, gnt_d;
  logic [IdxW-1:0]   id_q, id_d;
  logic              val_q, val_d;
  logic              timeout_q, timeout_d;
  logic [HoldW-1:0]  hold_q, hold_d;

  logic              holder_req;
  logic              hold_expired;
  logic [NumReq-1:0] arb_mask;
  logic [NumReq-1:0] arb_req;
  logic [NumReq-1:0] enc_in;
  logic [IdxW-1:0]   enc_idx;
  logic              enc_valid;
  logic [IdxW-1:0]   win_id;
  logic              do_arb;

  assign holder_req   = req[id_q];
  assign hold_expired = (hold_q >= HoldW'(MAX_HOLD));

  // While busy the current holder never competes: either it has released, or
  // it has just been force-terminated and must sit out this arbitration.
  assign arb_mask = (state_q == StBusy) ? idx_to_onehot(id_q) : '0;
  assign arb_req  = req & ~arb_mask;

`ifdef PRIORITY_ARBITER_RR_EN
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] start;

  assign start = ptr_q + IdxW'(1);

  // Rotate so the search start lands on the encoder's top bit; lower encoder
  // bits then correspond to successively higher (wrapping) indices.
  always_comb begin
    enc_in = '0;
    for (int k = 0; k < NumReq; k++) begin
      enc_in[NumReq-1-k] = arb_req[start + IdxW'(k)];
    end
  end

  // Encoder bit b maps back to offset (3 - b) = ~b from the start index.
  assign win_id = start + ~enc_idx;

  // Round-robin pointer: index of the most recent grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign enc_in = arb_req;
  assign win_id = enc_idx;
`endif

  prio_enc4 u_prio_enc4 (
    .req   (enc_in),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  // Next-state and next-output logic; defaults hold the current grant.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    id_d      = id_q;
    val_d     = val_q;
    timeout_d = 1'b0;
    hold_d    = hold_q;
    do_arb    = 1'b0;
`ifdef PRIORITY_ARBITER_RR_EN
    ptr_d     = ptr_q;
`endif

    unique case (state_q)
      StIdle: begin
        do_arb = 1'b1;
      end
      StBusy: begin
        if (holder_req && !hold_expired) begin
          // Below the limit, so the increment cannot pass MAX_HOLD.
          hold_d = hold_q + HoldW'(1);
        end else begin
          do_arb    = 1'b1;
          timeout_d = holder_req;
        end
      end
      default: begin
        do_arb = 1'b1;
      end
    endcase

    if (do_arb) begin
      if (enc_valid) begin
        state_d = StBusy;
        gnt_d   = idx_to_onehot(win_id);
        id_d    = win_id;
        val_d   = 1'b1;
        hold_d  = HoldW'(1);
`ifdef PRIORITY_ARBITER_RR_EN
        ptr_d   = win_id;
`endif
      end else begin
        state_d = StIdle;
        gnt_d   = '0;
        id_d    = '0;
        val_d   = 1'b0;
        hold_d  = '0;
      end
    end
  end

  // State and registered outputs; reset overrides any grant in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      gnt_q     <= '0;
      id_q      <= '0;
      val_q     <= 1'b0;
      timeout_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      id_q      <= id_d;
      val_q     <= val_d;
      timeout_q <= timeout_d;
      hold_q    <= hold_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = id_q;
  assign val     = val_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_priority_arbiter.sv
// Bench for priority_arbiter with MAX_HOLD = 4. Each driven cycle pushes the
// expected outputs from a behavioural model onto a scoreboard queue; they are
// popped and compared shortly after the following rising edge.
module tb_priority_arbiter;

  localparam int unsigned MaxHold = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       val;
  logic       timeout;

  priority_arbiter #(
    .MAX_HOLD (MaxHold)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .val     (val),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] id;
    logic       val;
    logic       tmo;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Behavioural model state.
  bit   m_busy = 1'b0;
  int   m_id   = 0;
  int   m_hold = 0;
  int   m_ptr  = 0;

  task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge and queue the expected outputs.
  task automatic model_step(bit r_rst, logic [3:0] r);
    exp_t       e;
    logic [3:0] cand;
    bit         pick;
    bit         found;
    int         nid;
    e     = '0;
    cand  = r;
    pick  = 1'b0;
    found = 1'b0;
    nid   = 0;
    if (r_rst) begin
      m_busy = 1'b0;
      m_id   = 0;
      m_hold = 0;
      m_ptr  = 0;
    end else begin
      pick = 1'b1;
      if (m_busy) begin
        if (r[m_id] && m_hold < int'(MaxHold)) begin
          m_hold++;
          pick = 1'b0;
        end else begin
          if (r[m_id]) e.tmo = 1'b1;
          cand[m_id] = 1'b0;
        end
      end
      if (pick) begin
`ifdef PRIORITY_ARBITER_RR_EN
        for (int k = 1; k <= 4; k++) begin
          int i;
          i = (m_ptr + k) % 4;
          if (!found && cand[i]) begin
            found = 1'b1;
            nid   = i;
          end
        end
`else
        for (int i = 3; i >= 0; i--) begin
          if (!found && cand[i]) begin
            found = 1'b1;
            nid   = i;
          end
        end
`endif
        if (found) begin
          m_busy = 1'b1;
          m_id   = nid;
          m_hold = 1;
          m_ptr  = nid;
        end else begin
          m_busy = 1'b0;
          m_id   = 0;
          m_hold = 0;
        end
      end
    end
    e.gnt = m_busy ? (4'b0001 << m_id) : 4'b0000;
    e.id  = m_busy ? m_id[1:0] : 2'd0;
    e.val = m_busy;
    sb_q.push_back(e);
  endtask

  // Drive one cycle of stimulus, then check the outputs after the edge.
  task automatic cycle(bit r_rst, logic [3:0] r);
    exp_t e;
    @(negedge clk);
    rst = r_rst;
    req = r;
    model_step(r_rst, r);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check("gnt", gnt, e.gnt);
      check("gnt_id", gnt_id, e.id);
      check("val", val, e.val);
      check("timeout", timeout, e.tmo);
      check("onehot", $countones(gnt) <= 1, 1);
    end
  endtask

  initial begin
    logic [3:0] rr_req [5];
    int         rr_exp [5];
    logic [3:0] r_cur;
    rst = 1'b1;
    req = 4'b0000;

    // Reset held for three cycles with every request asserted.
    repeat (3) begin
      cycle(1'b1, 4'b1111);
      check("rst_gnt", gnt, 4'b0000);
      check("rst_val", val, 1'b0);
      check("rst_tmo", timeout, 1'b0);
    end
    cycle(1'b0, 4'b1111);
`ifdef PRIORITY_ARBITER_RR_EN
    check("first_rr", gnt, 4'b0010);
`else
    check("first_fixed", gnt, 4'b1000);
`endif

    // Priority select, then handover with no gap when the holder drops.
    cycle(1'b1, 4'b0000);
    cycle(1'b0, 4'b0101);
    check("p_gnt", gnt, 4'b0100);
    check("p_id", gnt_id, 2'd2);
    cycle(1'b0, 4'b0001);
    check("hand_gnt", gnt, 4'b0001);
    check("hand_id", gnt_id, 2'd0);
    cycle(1'b0, 4'b0000);
    check("idle_val", val, 1'b0);

    // Forced termination hands over to a waiting requester.
    cycle(1'b1, 4'b0000);
    cycle(1'b0, 4'b0010);
    check("to_g1", gnt, 4'b0010);
    repeat (3) begin
      cycle(1'b0, 4'b1010);
      check("to_hold", gnt, 4'b0010);
      check("to_quiet", timeout, 1'b0);
    end
    cycle(1'b0, 4'b1010);
    check("to_next", gnt, 4'b1000);
    check("to_pulse", timeout, 1'b1);
    cycle(1'b0, 4'b1010);
    check("to_once", timeout, 1'b0);

    // Sole holder: one ungranted cycle, then re-granted.
    cycle(1'b1, 4'b0000);
    repeat (4) begin
      cycle(1'b0, 4'b0001);
      check("sole_hold", gnt, 4'b0001);
    end
    cycle(1'b0, 4'b0001);
    check("sole_gap", gnt, 4'b0000);
    check("sole_pulse", timeout, 1'b1);
    cycle(1'b0, 4'b0001);
    check("sole_regnt", gnt, 4'b0001);

    // Reset pulse while busy.
    cycle(1'b1, 4'b0000);
    cycle(1'b0, 4'b0100);
    cycle(1'b0, 4'b0100);
    cycle(1'b1, 4'b0100);
    check("midrst_gnt", gnt, 4'b0000);
    cycle(1'b0, 4'b0100);
    check("midrst_resume", gnt, 4'b0100);

`ifdef PRIORITY_ARBITER_RR_EN
    // Round-robin rotation, each holder releasing after one cycle.
    rr_req = '{4'b1111, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    rr_exp = '{1, 2, 3, 0, 1};
    cycle(1'b1, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, rr_req[i]);
      check("rr_order", gnt_id, rr_exp[i]);
    end
`else
    rr_req = '{default: 4'b0000};
    rr_exp = '{default: 0};
`endif

    // Random traffic with sticky requests and occasional reset.
    r_cur = 4'b0000;
    cycle(1'b1, r_cur);
    repeat (300) begin
      r_cur = r_cur ^ (4'($urandom) & 4'($urandom));
      cycle($urandom_range(0, 39) == 0, r_cur);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
